// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: instruction-memory port, redirect input and IF/ID hand-over.
// The fetch queue drives through the master modport; the environment uses slave.
interface fetch_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            deq_ready;
  logic            ifid_we;
  logic            ifid_empty;
  logic [XLEN-1:0] ifid_pc;
  logic [XLEN-1:0] ifid_instr;
  logic [CW-1:0]   count;

  modport master (
    output imem_addr, ifid_we, ifid_empty, ifid_pc, ifid_instr, count,
    input  imem_rdata, redirect_valid, redirect_pc, deq_ready
  );

  modport slave (
    input  imem_addr, ifid_we, ifid_empty, ifid_pc, ifid_instr, count,
    output imem_rdata, redirect_valid, redirect_pc, deq_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch with a small prefetch FIFO of {pc, instr} pairs feeding IF/ID.
// Sequential pc generation, flush-and-reload on redirect, no empty-queue bypass.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic     clk,
  input  logic     rst,
  fetch_if.master  fq
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  entry_t          q [DEPTH];
  logic [AW-1:0]   head, tail;
  logic [AW:0]     cnt;
  logic [XLEN-1:0] pc;
  logic            push, pop;

  // A full queue can still accept a fetch when the head leaves in the same cycle.
  assign pop  = fq.deq_ready && (cnt != '0) && !fq.redirect_valid;
  assign push = !fq.redirect_valid && ((cnt < (AW+1)'(DEPTH)) || pop);

  assign fq.imem_addr  = pc;
  assign fq.ifid_we    = fq.deq_ready;
  assign fq.ifid_empty = (cnt == '0) || fq.redirect_valid;
  assign fq.ifid_pc    = q[head].pc;
  assign fq.ifid_instr = q[head].instr;
  assign fq.count      = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc   <= RESET_PC;
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (fq.redirect_valid) begin
      pc   <= fq.redirect_pc;
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) begin
        tail <= tail + AW'(1);
        pc   <= pc + XLEN'(4);
      end
      if (pop) head <= head + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage carries no reset; head/tail/count alone define validity.
  always_ff @(posedge clk) begin
    if (!rst && push) q[tail] <= entry_t'{pc: pc, instr: fq.imem_rdata};
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (cnt <= (AW+1)'(DEPTH));
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Randomized scoreboard bench for fetch_queue against a queue-level reference model.
module tb_fetch_queue;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_if #(.XLEN(XLEN), .DEPTH(DEPTH)) fq ();

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC('0)) dut (
    .clk (clk),
    .rst (rst),
    .fq  (fq)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign fq.imem_rdata = instr_of(fq.imem_addr);

  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  typedef struct { bit rst; bit we; bit empty; int cnt; logic [31:0] addr; } st_t;

  ent_t        mq[$];   // model contents of the prefetch queue
  ent_t        hq[$];   // expected hand-overs to IF/ID
  st_t         sq[$];   // expected per-cycle status
  logic [31:0] mpc;
  bit          model_ok = 0;
  int          n_pass = 0;
  int          n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // One cycle of stimulus; the model predicts the effect of the coming posedge.
  task automatic cyc(input bit r, input bit rv, input logic [31:0] rp, input bit dr);
    st_t  s;
    ent_t e;
    bit   do_pop, do_push;
    @(negedge clk);
    rst = r;
    fq.redirect_valid = rv;
    fq.redirect_pc = rp;
    fq.deq_ready = dr;
    if (model_ok) begin
      s.rst = r; s.we = dr; s.empty = (mq.size() == 0) || rv;
      s.cnt = mq.size(); s.addr = mpc;
      sq.push_back(s);
    end
    if (r) begin
      mq.delete(); mpc = 32'h0; model_ok = 1;
    end else if (rv) begin
      mq.delete(); mpc = rp;
    end else begin
      do_pop  = dr && (mq.size() > 0);
      do_push = (mq.size() < DEPTH) || do_pop;
      if (do_pop) begin
        e = mq.pop_front();
        hq.push_back(e);
      end
      if (do_push) begin
        e.pc = mpc; e.instr = instr_of(mpc);
        mq.push_back(e);
        mpc = mpc + 32'd4;
      end
    end
  endtask

  initial begin : monitor
    st_t  s;
    ent_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sq.size() != 0) begin
        s = sq.pop_front();
        chk("count", 32'(fq.count), 32'(s.cnt));
        chk("ifid_empty", 32'(fq.ifid_empty), 32'(s.empty));
        chk("ifid_we", 32'(fq.ifid_we), 32'(s.we));
        chk("imem_addr", fq.imem_addr, s.addr);
        if (!s.rst && fq.ifid_we && !fq.ifid_empty) begin
          if (hq.size() == 0) begin
            n_total++;
            $display("FAIL handover: got pc %h with no expected entry", fq.ifid_pc);
          end else begin
            e = hq.pop_front();
            chk("ifid_pc", fq.ifid_pc, e.pc);
            chk("ifid_instr", fq.ifid_instr, e.instr);
          end
        end
      end
    end
  end

  initial begin : stim
    logic [31:0] rp;
    fq.redirect_valid = 1'b0;
    fq.redirect_pc = '0;
    fq.deq_ready = 1'b0;

    // streaming from reset
    cyc(1, 0, 0, 1); cyc(1, 0, 0, 1);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1);

    // fill to full and hold, then drain in order
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1);

    // redirect with three entries queued
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    cyc(0, 1, 32'h100, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);

    // reset and redirect together: reset wins
    cyc(1, 1, 32'h100, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);

    // pc wrap plus head/tail wrap over several queue lengths
    cyc(0, 1, 32'hFFFF_FFFC, 0);
    for (int i = 0; i < 3 * DEPTH + 4; i++) cyc(0, 0, 0, 1'($urandom_range(0, 1)));

    // random mix
    for (int i = 0; i < 1500; i++) begin
      rp = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                       : $urandom;
      cyc(($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0,
          ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0,
          rp,
          ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0);
    end

    repeat (3) @(negedge clk);
    chk("drain", 32'(hq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
